// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite slave front-end and its
// acknowledge/timeout helper.
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_ISSUE   = 2'd1,
        W_WAIT    = 2'd2,
        W_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAIT  = 2'd2,
        R_RESP  = 2'd3
    } rd_state_e;

    // Register accesses are whole 32-bit words, so the two low address bits must be zero.
    localparam int ALIGN_LSB_W = 2;
    localparam logic [ALIGN_LSB_W-1:0] ALIGN_ZERO = 2'b00;

    function automatic logic addr_aligned(input logic [ALIGN_LSB_W-1:0] lsbs);
        return (lsbs == ALIGN_ZERO);
    endfunction

endpackage

// File: rtl/axil_txn_wait.sv
// Waits for a single-cycle register acknowledge and flags a timeout when none
// arrives within TIMEOUT cycles; an ack in the last counting cycle still wins.
module axil_txn_wait
    import axil_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic done,
    output logic timed_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;

    // Saturating wait counter, cleared on the cycle before the wait begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (start) begin
            cnt_r <= CNT_ZERO;
        end else if (active && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Completion decode; ack has priority over the timeout in the last cycle.
    always_comb begin
        done      = active & ack;
        timed_out = active & ~ack & (cnt_r == CNT_LAST);
    end

endmodule

// File: rtl/axil_slave_if.sv
// AXI4-Lite slave front-end: turns each accepted write or read into a single
// request pulse toward the register block and returns a held B/R response.
module axil_slave_if
    import axil_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                reg_awvalid,
    output logic                reg_wvalid,
    output logic [ADDR_W-1:0]   reg_awaddr,
    output logic [DATA_W-1:0]   reg_wdata,
    input  logic                reg_bvalid,
    output logic                reg_arvalid,
    output logic [ADDR_W-1:0]   reg_araddr,
    input  logic                reg_rvalid,
    input  logic [DATA_W-1:0]   reg_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [STRB_W-1:0] STRB_ALL  = {STRB_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [STRB_W-1:0] STRB_ZERO = {STRB_W{1'b0}};

    // ---------------- write path ----------------
    wr_state_e         wr_state_r, wr_next_s;
    logic              aw_held_r, w_held_r, aw_held_nx_s, w_held_nx_s;
    logic [ADDR_W-1:0] aw_addr_r, aw_addr_nx_s;
    logic [DATA_W-1:0] w_data_r, w_data_nx_s;
    logic [STRB_W-1:0] w_strb_r, w_strb_nx_s;
    logic              aw_fire_s, w_fire_s, b_fire_s, wr_ok_s;
    logic              wr_start_s, wr_done_s, wr_tmo_s;
    logic              awready_r, wready_r, wr_pulse_r, bvalid_r;
    logic [ADDR_W-1:0] reg_awaddr_r;
    logic [DATA_W-1:0] reg_wdata_r;
    resp_e             bresp_r;
    logic              awready_d_s, wready_d_s, wr_pulse_d_s, bvalid_d_s;
    logic [ADDR_W-1:0] reg_awaddr_d_s;
    logic [DATA_W-1:0] reg_wdata_d_s;
    resp_e             bresp_d_s;

    // Beat capture: the values the holding registers take at the next edge.
    always_comb begin
        aw_fire_s    = awvalid & awready_r;
        w_fire_s     = wvalid & wready_r;
        b_fire_s     = bvalid_r & bready;
        aw_addr_nx_s = aw_fire_s ? awaddr : aw_addr_r;
        w_data_nx_s  = w_fire_s ? wdata : w_data_r;
        w_strb_nx_s  = w_fire_s ? wstrb : w_strb_r;
        if ((wr_state_r == W_RESP) && b_fire_s) begin
            aw_held_nx_s = 1'b0;
            w_held_nx_s  = 1'b0;
        end else begin
            aw_held_nx_s = aw_held_r | aw_fire_s;
            w_held_nx_s  = w_held_r | w_fire_s;
        end
        wr_ok_s    = addr_aligned(aw_addr_nx_s[ALIGN_LSB_W-1:0]) && (w_strb_nx_s == STRB_ALL);
        wr_start_s = (wr_state_r == W_ISSUE) && wr_ok_s;
    end

    // Holding registers for the AW and W beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_addr_r <= ADDR_ZERO;
            w_data_r  <= DATA_ZERO;
            w_strb_r  <= STRB_ZERO;
        end else begin
            aw_held_r <= aw_held_nx_s;
            w_held_r  <= w_held_nx_s;
            aw_addr_r <= aw_addr_nx_s;
            w_data_r  <= w_data_nx_s;
            w_strb_r  <= w_strb_nx_s;
        end
    end

    axil_txn_wait #(.TIMEOUT(TIMEOUT)) u_wr_wait (
        .clk       (clk),
        .rst       (rst),
        .start     (wr_start_s),
        .active    (wr_state_r == W_WAIT),
        .ack       (reg_bvalid),
        .done      (wr_done_s),
        .timed_out (wr_tmo_s)
    );

    // Write FSM next-state.
    always_comb begin
        wr_next_s = wr_state_r;
        case (wr_state_r)
            W_COLLECT: if (aw_held_nx_s && w_held_nx_s) wr_next_s = W_ISSUE; else wr_next_s = W_COLLECT;
            W_ISSUE:   if (wr_ok_s) wr_next_s = W_WAIT; else wr_next_s = W_RESP;
            W_WAIT:    if (wr_done_s || wr_tmo_s) wr_next_s = W_RESP; else wr_next_s = W_WAIT;
            W_RESP:    if (b_fire_s) wr_next_s = W_COLLECT; else wr_next_s = W_RESP;
            default:   wr_next_s = W_COLLECT;
        endcase
    end

    // Write FSM outputs, computed one cycle early so every port is a flop.
    always_comb begin
        awready_d_s    = (wr_next_s == W_COLLECT) && !aw_held_nx_s;
        wready_d_s     = (wr_next_s == W_COLLECT) && !w_held_nx_s;
        wr_pulse_d_s   = (wr_next_s == W_ISSUE) && wr_ok_s;
        reg_awaddr_d_s = wr_pulse_d_s ? aw_addr_nx_s : ADDR_ZERO;
        reg_wdata_d_s  = wr_pulse_d_s ? w_data_nx_s : DATA_ZERO;
        bvalid_d_s     = (wr_next_s == W_RESP);
        bresp_d_s      = bresp_r;
        case (wr_state_r)
            W_ISSUE: begin
                if (!wr_ok_s) bresp_d_s = RESP_SLVERR; else bresp_d_s = bresp_r;
            end
            W_WAIT: begin
                if (wr_done_s)     bresp_d_s = RESP_OKAY;
                else if (wr_tmo_s) bresp_d_s = RESP_SLVERR;
                else               bresp_d_s = bresp_r;
            end
            default: bresp_d_s = bresp_r;
        endcase
    end

    // Write FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r   <= W_COLLECT;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            wr_pulse_r   <= 1'b0;
            reg_awaddr_r <= ADDR_ZERO;
            reg_wdata_r  <= DATA_ZERO;
            bvalid_r     <= 1'b0;
            bresp_r      <= RESP_OKAY;
        end else begin
            wr_state_r   <= wr_next_s;
            awready_r    <= awready_d_s;
            wready_r     <= wready_d_s;
            wr_pulse_r   <= wr_pulse_d_s;
            reg_awaddr_r <= reg_awaddr_d_s;
            reg_wdata_r  <= reg_wdata_d_s;
            bvalid_r     <= bvalid_d_s;
            bresp_r      <= bresp_d_s;
        end
    end

    // ---------------- read path ----------------
    rd_state_e         rd_state_r, rd_next_s;
    logic [ADDR_W-1:0] ar_addr_r, ar_addr_nx_s;
    logic              ar_fire_s, r_fire_s, rd_ok_s;
    logic              rd_start_s, rd_done_s, rd_tmo_s;
    logic              arready_r, rd_pulse_r, rvalid_r;
    logic [ADDR_W-1:0] reg_araddr_r;
    logic [DATA_W-1:0] rdata_r;
    resp_e             rresp_r;
    logic              arready_d_s, rd_pulse_d_s, rvalid_d_s;
    logic [ADDR_W-1:0] reg_araddr_d_s;
    logic [DATA_W-1:0] rdata_d_s;
    resp_e             rresp_d_s;

    // Read address capture and alignment check.
    always_comb begin
        ar_fire_s    = arvalid & arready_r;
        r_fire_s     = rvalid_r & rready;
        ar_addr_nx_s = ar_fire_s ? araddr : ar_addr_r;
        rd_ok_s      = addr_aligned(ar_addr_nx_s[ALIGN_LSB_W-1:0]);
        rd_start_s   = (rd_state_r == R_ISSUE) && rd_ok_s;
    end

    axil_txn_wait #(.TIMEOUT(TIMEOUT)) u_rd_wait (
        .clk       (clk),
        .rst       (rst),
        .start     (rd_start_s),
        .active    (rd_state_r == R_WAIT),
        .ack       (reg_rvalid),
        .done      (rd_done_s),
        .timed_out (rd_tmo_s)
    );

    // Read FSM next-state.
    always_comb begin
        rd_next_s = rd_state_r;
        case (rd_state_r)
            R_IDLE:  if (ar_fire_s) rd_next_s = R_ISSUE; else rd_next_s = R_IDLE;
            R_ISSUE: if (rd_ok_s) rd_next_s = R_WAIT; else rd_next_s = R_RESP;
            R_WAIT:  if (rd_done_s || rd_tmo_s) rd_next_s = R_RESP; else rd_next_s = R_WAIT;
            R_RESP:  if (r_fire_s) rd_next_s = R_IDLE; else rd_next_s = R_RESP;
            default: rd_next_s = R_IDLE;
        endcase
    end

    // Read FSM outputs; rdata/rresp only change on entry to R_RESP.
    always_comb begin
        arready_d_s    = (rd_next_s == R_IDLE);
        rd_pulse_d_s   = (rd_next_s == R_ISSUE) && rd_ok_s;
        reg_araddr_d_s = rd_pulse_d_s ? ar_addr_nx_s : ADDR_ZERO;
        rvalid_d_s     = (rd_next_s == R_RESP);
        rdata_d_s      = rdata_r;
        rresp_d_s      = rresp_r;
        case (rd_state_r)
            R_ISSUE: begin
                if (!rd_ok_s) begin
                    rdata_d_s = DATA_ZERO;
                    rresp_d_s = RESP_SLVERR;
                end else begin
                    rdata_d_s = rdata_r;
                    rresp_d_s = rresp_r;
                end
            end
            R_WAIT: begin
                if (rd_done_s) begin
                    rdata_d_s = reg_rdata;
                    rresp_d_s = RESP_OKAY;
                end else if (rd_tmo_s) begin
                    rdata_d_s = DATA_ZERO;
                    rresp_d_s = RESP_SLVERR;
                end else begin
                    rdata_d_s = rdata_r;
                    rresp_d_s = rresp_r;
                end
            end
            default: begin
                rdata_d_s = rdata_r;
                rresp_d_s = rresp_r;
            end
        endcase
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r   <= R_IDLE;
            ar_addr_r    <= ADDR_ZERO;
            arready_r    <= 1'b0;
            rd_pulse_r   <= 1'b0;
            reg_araddr_r <= ADDR_ZERO;
            rvalid_r     <= 1'b0;
            rdata_r      <= DATA_ZERO;
            rresp_r      <= RESP_OKAY;
        end else begin
            rd_state_r   <= rd_next_s;
            ar_addr_r    <= ar_addr_nx_s;
            arready_r    <= arready_d_s;
            rd_pulse_r   <= rd_pulse_d_s;
            reg_araddr_r <= reg_araddr_d_s;
            rvalid_r     <= rvalid_d_s;
            rdata_r      <= rdata_d_s;
            rresp_r      <= rresp_d_s;
        end
    end

    assign awready     = awready_r;
    assign wready      = wready_r;
    assign bvalid      = bvalid_r;
    assign bresp       = bresp_r;
    assign reg_awvalid = wr_pulse_r;
    assign reg_wvalid  = wr_pulse_r;
    assign reg_awaddr  = reg_awaddr_r;
    assign reg_wdata   = reg_wdata_r;
    assign arready     = arready_r;
    assign rvalid      = rvalid_r;
    assign rdata       = rdata_r;
    assign rresp       = rresp_r;
    assign reg_arvalid = rd_pulse_r;
    assign reg_araddr  = reg_araddr_r;

endmodule

// File: tb/tb_axil_slave_if.sv
// Directed self-checking bench for axil_slave_if: inputs change 1 time unit
// after each rising edge, outputs are sampled at the same point.
module tb_axil_slave_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [7:0]  awaddr, araddr, reg_awaddr, reg_araddr;
    logic [31:0] wdata, rdata, reg_wdata, reg_rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        reg_awvalid, reg_wvalid, reg_bvalid, reg_arvalid, reg_rvalid;

    int total = 0;
    int bad   = 0;
    int aw_pulses = 0;
    int ar_pulses = 0;

    axil_slave_if #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_awvalid(reg_awvalid), .reg_wvalid(reg_wvalid),
        .reg_awaddr(reg_awaddr), .reg_wdata(reg_wdata), .reg_bvalid(reg_bvalid),
        .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr),
        .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    // Count request pulses seen by the register block.
    always @(posedge clk) begin
        if (reg_awvalid) aw_pulses <= aw_pulses + 1;
        if (reg_arvalid) ar_pulses <= ar_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if ({awready, wready, arready} !== 3'b000) begin bad++; $display("FAIL rst_ready: got %b exp 000", {awready, wready, arready}); end
        total++; if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin bad++; $display("FAIL rst_resp: got %b exp 000000", {bvalid, rvalid, bresp, rresp}); end
        total++; if ({rdata, reg_awvalid, reg_wvalid, reg_arvalid, reg_awaddr, reg_araddr, reg_wdata} !== 83'd0) begin bad++; $display("FAIL rst_regside: got %h exp 0", {rdata, reg_awvalid, reg_wvalid, reg_arvalid, reg_awaddr, reg_araddr, reg_wdata}); end
        rst = 1'b0;
        tick();
        total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL rel_ready: got %b exp 111", {awready, wready, arready}); end
    endtask

    task automatic test_write_basic();
        int p0 = aw_pulses;
        awvalid = 1'b1; awaddr = 8'h08; wvalid = 1'b1; wdata = 32'h0000_0010; wstrb = 4'hF;
        tick();  // cycle 0 handshake
        awvalid = 1'b0; wvalid = 1'b0;
        total++; if ({awready, wready} !== 2'b00) begin bad++; $display("FAIL wb_ready_drop: got %b exp 00", {awready, wready}); end
        total++; if ({reg_awvalid, reg_wvalid, reg_awaddr, reg_wdata} !== {2'b11, 8'h08, 32'h0000_0010}) begin bad++; $display("FAIL wb_pulse: got %b%b %h %h exp 11 08 00000010", reg_awvalid, reg_wvalid, reg_awaddr, reg_wdata); end
        tick();  // cycle 2, waiting
        total++; if ({reg_awvalid, bvalid} !== 2'b00) begin bad++; $display("FAIL wb_pulse_len: got %b exp 00", {reg_awvalid, bvalid}); end
        reg_bvalid = 1'b1;
        tick();  // cycle 3
        reg_bvalid = 1'b0;
        total++; if ({bvalid, bresp} !== 3'b100) begin bad++; $display("FAIL wb_bresp: got %b exp 100", {bvalid, bresp}); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        total++; if ({bvalid, awready, wready} !== 3'b011) begin bad++; $display("FAIL wb_after_b: got %b exp 011", {bvalid, awready, wready}); end
        total++; if (aw_pulses - p0 !== 1) begin bad++; $display("FAIL wb_pulse_cnt: got %0d exp 1", aw_pulses - p0); end
    endtask

    task automatic test_w_before_aw();
        logic stable = 1'b1;
        wvalid = 1'b1; wdata = 32'h55AA_0001; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        total++; if ({wready, awready} !== 2'b01) begin bad++; $display("FAIL wa_wready_drop: got %b exp 01", {wready, awready}); end
        tick();
        tick();
        total++; if (reg_awvalid !== 1'b0) begin bad++; $display("FAIL wa_early_pulse: got %b exp 0", reg_awvalid); end
        awvalid = 1'b1; awaddr = 8'h0C;
        tick();
        awvalid = 1'b0;
        total++; if ({reg_awvalid, reg_awaddr, reg_wdata} !== {1'b1, 8'h0C, 32'h55AA_0001}) begin bad++; $display("FAIL wa_pulse: got %b %h %h exp 1 0c 55aa0001", reg_awvalid, reg_awaddr, reg_wdata); end
        tick();
        reg_bvalid = 1'b1;
        tick();
        reg_bvalid = 1'b0;
        total++; if ({bvalid, bresp} !== 3'b100) begin bad++; $display("FAIL wa_bresp: got %b exp 100", {bvalid, bresp}); end
        for (int i = 0; i < 5; i++) begin
            reg_bvalid = (i == 2);  // stray ack while holding must not disturb the response
            awvalid = 1'b1; wvalid = 1'b1;
            tick();
            if ({bvalid, bresp, awready, wready} !== 5'b10000) stable = 1'b0;
        end
        reg_bvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL wa_hold_stable: got %b exp 1", stable); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL wa_b_done: got %b exp 0", bvalid); end
    endtask

    task automatic test_read_basic();
        arvalid = 1'b1; araddr = 8'h14;
        tick();
        arvalid = 1'b0;
        total++; if ({arready, reg_arvalid, reg_araddr} !== {2'b01, 8'h14}) begin bad++; $display("FAIL rb_pulse: got %b%b %h exp 01 14", arready, reg_arvalid, reg_araddr); end
        tick();
        total++; if ({reg_arvalid, rvalid} !== 2'b00) begin bad++; $display("FAIL rb_pulse_len: got %b exp 00", {reg_arvalid, rvalid}); end
        reg_rvalid = 1'b1; reg_rdata = 32'hDEAD_BEEF;
        tick();
        reg_rvalid = 1'b0; reg_rdata = 32'h1234_5678;
        total++; if ({rvalid, rresp, rdata} !== {3'b100, 32'hDEAD_BEEF}) begin bad++; $display("FAIL rb_resp: got %b %b %h exp 1 00 deadbeef", rvalid, rresp, rdata); end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL rb_after_r: got %b exp 01", {rvalid, arready}); end
    endtask

    task automatic test_misaligned();
        int pa = aw_pulses;
        int pr = ar_pulses;
        arvalid = 1'b1; araddr = 8'h05;
        tick();
        arvalid = 1'b0;
        tick();
        total++; if ({rvalid, rresp, rdata} !== {3'b110, 32'h0}) begin bad++; $display("FAIL mis_rd_resp: got %b %b %h exp 1 10 00000000", rvalid, rresp, rdata); end
        rready = 1'b1; tick(); rready = 1'b0;
        awvalid = 1'b1; awaddr = 8'h10; wvalid = 1'b1; wdata = 32'hFFFF_0000; wstrb = 4'h3;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        total++; if ({bvalid, bresp} !== 3'b110) begin bad++; $display("FAIL mis_wr_resp: got %b exp 110", {bvalid, bresp}); end
        bready = 1'b1; tick(); bready = 1'b0;
        total++; if ((aw_pulses - pa) + (ar_pulses - pr) !== 0) begin bad++; $display("FAIL mis_no_pulse: got %0d exp 0", (aw_pulses - pa) + (ar_pulses - pr)); end
    endtask

    task automatic test_read_timeout();
        arvalid = 1'b1; araddr = 8'h20;
        tick();
        arvalid = 1'b0;
        repeat (16) tick();  // now in cycle 17, last counting cycle
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL to_early: got %b exp 0", rvalid); end
        tick();
        total++; if ({rvalid, rresp, rdata} !== {3'b110, 32'h0}) begin bad++; $display("FAIL to_resp: got %b %b %h exp 1 10 00000000", rvalid, rresp, rdata); end
        reg_rvalid = 1'b1; reg_rdata = 32'h0000_CAFE;
        tick();
        reg_rvalid = 1'b0;
        total++; if ({rvalid, rresp, rdata} !== {3'b110, 32'h0}) begin bad++; $display("FAIL to_late_ack: got %b %b %h exp 1 10 00000000", rvalid, rresp, rdata); end
        rready = 1'b1; tick(); rready = 1'b0;
        tick();
        total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL to_drain: got %b exp 01", {rvalid, arready}); end
        // ack in the last counting cycle beats the timeout
        arvalid = 1'b1; araddr = 8'h24;
        tick();
        arvalid = 1'b0;
        repeat (16) tick();
        reg_rvalid = 1'b1; reg_rdata = 32'h0BAD_F00D;
        tick();
        reg_rvalid = 1'b0;
        total++; if ({rvalid, rresp, rdata} !== {3'b100, 32'h0BAD_F00D}) begin bad++; $display("FAIL to_last_ack: got %b %b %h exp 1 00 0badf00d", rvalid, rresp, rdata); end
        rready = 1'b1; tick(); rready = 1'b0;
    endtask

    task automatic test_concurrent_reset();
        logic seen = 1'b0;
        int pa;
        awvalid = 1'b1; awaddr = 8'h30; wvalid = 1'b1; wdata = 32'h0000_0030; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 8'h34;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        total++; if ({reg_awvalid, reg_arvalid} !== 2'b11) begin bad++; $display("FAIL cc_pulses: got %b exp 11", {reg_awvalid, reg_arvalid}); end
        tick();  // both paths waiting
        rst = 1'b1;
        tick();
        total++; if ({awready, wready, arready, bvalid, rvalid, reg_awvalid, reg_arvalid} !== 7'b0) begin bad++; $display("FAIL cc_rst_outs: got %b exp 0000000", {awready, wready, arready, bvalid, rvalid, reg_awvalid, reg_arvalid}); end
        rst = 1'b0;
        tick();
        reg_bvalid = 1'b1; reg_rvalid = 1'b1;
        tick();
        reg_bvalid = 1'b0; reg_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b0 || rvalid !== 1'b0) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL cc_no_resp: got %b exp 0", seen); end
        // a lone AW after reset must not pair with a discarded W beat
        pa = aw_pulses;
        awvalid = 1'b1; awaddr = 8'h38;
        tick();
        awvalid = 1'b0;
        tick(); tick();
        total++; if ((aw_pulses - pa) !== 0 || wready !== 1'b1) begin bad++; $display("FAIL cc_held_cleared: got pulses=%0d wready=%b exp 0 1", aw_pulses - pa, wready); end
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awaddr = 8'h00; wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; bready = 1'b0;
        arvalid = 1'b0; araddr = 8'h00; rready = 1'b0;
        reg_bvalid = 1'b0; reg_rvalid = 1'b0; reg_rdata = 32'h0;
        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_read_basic();
        test_misaligned();
        test_read_timeout();
        test_concurrent_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
